// File: rtl/hlsm_operand_sequencer.sv
// Purpose: buffers (a,b,c) operand triples, runs the HLSM datapath once per triple, returns z/x with a Done timeout.
// Latency: result valid 9 cycles after a triple is accepted into an idle, empty sequencer; 9 cycles per triple back-to-back.
// Backpressure: in_ready drops while the operand FIFO is full; a result is held in HOLD until out_ready accepts it.
module hlsm_operand_sequencer #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z,
    output logic [W-1:0] out_x,
    output logic         out_err,
    output logic         hlsm_start,
    output logic [W-1:0] hlsm_a,
    output logic [W-1:0] hlsm_b,
    output logic [W-1:0] hlsm_c,
    input  logic         hlsm_done,
    input  logic [W-1:0] hlsm_z,
    input  logic [W-1:0] hlsm_x,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // operand FIFO storage and pointers
    logic [3*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // control FSM and registered outputs
    logic [1:0]     state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           start_q, start_d;
    logic [W-1:0]   hlsm_a_q, hlsm_a_d;
    logic [W-1:0]   hlsm_b_q, hlsm_b_d;
    logic [W-1:0]   hlsm_c_q, hlsm_c_d;
    logic           out_valid_q, out_valid_d;
    logic           out_err_q, out_err_d;
    logic [W-1:0]   out_z_q, out_z_d;
    logic [W-1:0]   out_x_q, out_x_d;

    logic           push;
    logic           pop;
    logic [3*W-1:0] head;

    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid && in_ready;
    // The FIFO is only drained when the FSM is idle, so at most one run is in flight.
    assign pop      = (state_q == ST_IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;
    assign out_z      = out_z_q;
    assign out_x      = out_x_q;
    assign hlsm_start = start_q;
    assign hlsm_a     = hlsm_a_q;
    assign hlsm_b     = hlsm_b_q;
    assign hlsm_c     = hlsm_c_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != '0);

    // FIFO pointer and occupancy update; pointers wrap naturally at a power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO data array write; contents need no reset because the pointers qualify them
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_c};
        end
    end

    // Sequencing FSM: pop operands, pulse Start, wait for Done or timeout, hold the result
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        start_d     = 1'b0;
        hlsm_a_d    = hlsm_a_q;
        hlsm_b_d    = hlsm_b_q;
        hlsm_c_d    = hlsm_c_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_z_d     = out_z_q;
        out_x_d     = out_x_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    // Operands are latched here and held until the next pop because the
                    // datapath reads them in several of its states.
                    hlsm_a_d = head[3*W-1:2*W];
                    hlsm_b_d = head[2*W-1:W];
                    hlsm_c_d = head[W-1:0];
                    start_d  = 1'b1;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmo_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // Done takes priority over a coincident timeout.
                if (hlsm_done) begin
                    out_z_d     = hlsm_z;
                    out_x_d     = hlsm_x;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    out_z_d     = '0;
                    out_x_d     = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any in-flight run
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            start_q     <= 1'b0;
            hlsm_a_q    <= '0;
            hlsm_b_q    <= '0;
            hlsm_c_q    <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_z_q     <= '0;
            out_x_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            start_q     <= start_d;
            hlsm_a_q    <= hlsm_a_d;
            hlsm_b_q    <= hlsm_b_d;
            hlsm_c_q    <= hlsm_c_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_z_q     <= out_z_d;
            out_x_q     <= out_x_d;
        end
    end

endmodule

// File: tb/tb_hlsm_operand_sequencer.sv
// Bench for hlsm_operand_sequencer: behavioural HLSM model (Done 6 cycles after Start),
// scoreboard of expected results compared at each output handshake, directed steps.
module tb_hlsm_operand_sequencer;

    localparam int W       = 32;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [W-1:0] z;
        logic [W-1:0] x;
        logic         err;
    } res_t;

    logic         Clk;
    logic         Rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b, in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z, out_x;
    logic         out_err;
    logic         hlsm_start;
    logic [W-1:0] hlsm_a, hlsm_b, hlsm_c;
    logic         hlsm_done;
    logic [W-1:0] hlsm_z, hlsm_x;
    logic         busy;

    int   checks;
    int   errors;
    int   start_cycles;
    res_t exp_q[$];

    hlsm_operand_sequencer #(.W(W), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_x      (out_x),
        .out_err    (out_err),
        .hlsm_start (hlsm_start),
        .hlsm_a     (hlsm_a),
        .hlsm_b     (hlsm_b),
        .hlsm_c     (hlsm_c),
        .hlsm_done  (hlsm_done),
        .hlsm_z     (hlsm_z),
        .hlsm_x     (hlsm_x),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- HLSM behavioural model ----------------
    // Start seen at the end of cycle N; Done high in cycle N+6 unless hang is set.
    logic              hang;
    logic [2:0]        m_cnt;
    logic              run_valid;
    logic signed [W-1:0] la, lb, lc, ac;
    logic [W-1:0]      lau, lbu, lcu;

    always @(posedge Clk) begin
        if (hlsm_start) begin
            m_cnt     <= 3'd1;
            la        <= hlsm_a;
            lb        <= hlsm_b;
            lc        <= hlsm_c;
            lau       <= hlsm_a;
            lbu       <= hlsm_b;
            lcu       <= hlsm_c;
            run_valid <= 1'b1;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= (m_cnt == 3'd6) ? 3'd0 : m_cnt + 3'd1;
        end
        if (Rst) run_valid <= 1'b0;
    end

    always_comb begin
        ac        = la * lc;
        hlsm_x    = ac - la - lb;
        hlsm_z    = (la < lb) ? (ac + la + lb) : (ac + la + lc);
        hlsm_done = (m_cnt == 3'd6) && !hang;
    end

    // Operands must not move while the datapath is running.
    always @(negedge Clk) begin
        if (hlsm_done && run_valid) begin
            chk("hlsm_a_stable", hlsm_a, lau);
            chk("hlsm_b_stable", hlsm_b, lbu);
            chk("hlsm_c_stable", hlsm_c, lcu);
        end
    end

    always @(negedge Clk) begin
        if (hlsm_start) start_cycles <= start_cycles + 1;
    end

    // ---------------- scoreboard ----------------
    always @(negedge Clk) begin
        res_t e;
        if (!Rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_z", out_z, e.z);
                chk("out_x", out_x, e.x);
                chk("out_err", out_err, e.err);
            end
        end
    end

    // Drive one triple until accepted; expected result queued at acceptance.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] z, input logic [W-1:0] x, input logic err,
                        output int waited);
        res_t e;
        bit   ok;
        ok       = 0;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (in_ready) begin
                e.z = z; e.x = x; e.err = err;
                exp_q.push_back(e);
                ok = 1;
                @(posedge Clk); #1;
                break;
            end
            @(posedge Clk); #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) chk("push_accept_timeout", 64'd0, 64'd1);
    endtask

    // Cycles from acceptance to out_valid; the cycle after acceptance counts as 1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i < 100; i++) begin
            @(negedge Clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (!busy && !out_valid && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
        if (!ok) chk("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int lat;
        int sc0;
        bit seen;
        checks       = 0;
        errors       = 0;
        start_cycles = 0;
        hang         = 1'b0;
        m_cnt        = 3'd0;
        run_valid    = 1'b0;
        la = '0; lb = '0; lc = '0; lau = '0; lbu = '0; lcu = '0;
        Rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;

        // Reset state
        @(negedge Clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", hlsm_start, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_hlsm_a", hlsm_a, 0);
        @(posedge Clk); #1;

        // Single triple: 9-cycle latency, one-cycle Start
        sc0 = start_cycles;
        push(5, 7, 3, 27, 3, 1'b0, w);
        chk("t1_no_wait", w, 0);
        wait_valid(lat);
        chk("t1_latency", lat, 9);
        wait_idle();
        chk("t1_start_width", start_cycles - sc0, 1);

        // Signed operands and g=0 path, back to back
        push(-3, -1, 2, -10, -2, 1'b0, w);
        push(10, 2, 4, 54, 28, 1'b0, w);
        wait_idle();

        // Held result, FIFO fills behind it, fifth accepted only after the first pop
        out_ready = 1'b0;
        push(3, 4, 5, 22, 8, 1'b0, w);
        wait_valid(lat);
        chk("hold_latency", lat, 9);
        sc0 = start_cycles;
        push(1, 2, 3, 6, 0, 1'b0, w);    chk("burst0_wait", w, 0);
        push(4, 1, 2, 14, 3, 1'b0, w);   chk("burst1_wait", w, 0);
        push(-2, 5, -3, 9, 3, 1'b0, w);  chk("burst2_wait", w, 0);
        push(0, 0, 9, 9, 0, 1'b0, w);    chk("burst3_wait", w, 0);
        @(negedge Clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        @(posedge Clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_z", out_z, 22);
            chk("hold_x", out_x, 8);
            chk("hold_err", out_err, 0);
            chk("hold_no_start", hlsm_start, 0);
            @(posedge Clk); #1;
        end
        chk("hold_start_count", start_cycles - sc0, 0);
        out_ready = 1'b1;
        push(6, 8, -1, 8, -20, 1'b0, w);
        chk("burst4_wait", w, 2);
        wait_idle();

        // Hung datapath: timeout result, then a normal run
        hang = 1'b1;
        push(1, 1, 1, 0, 0, 1'b1, w);
        wait_valid(lat);
        chk("tmo_latency", lat, TIMEOUT + 3);
        wait_idle();
        hang = 1'b0;
        push(5, 7, 3, 27, 3, 1'b0, w);
        wait_idle();

        // Reset during BUSY followed by a late Done
        push(2, 9, 1, 0, 0, 1'b0, w);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (m_cnt == 3'd3) begin
                seen = 1;
                break;
            end
            @(posedge Clk); #1;
        end
        chk("rst_run_reached_busy", seen, 1);
        @(posedge Clk); #1;
        Rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            chk("post_rst_no_valid", out_valid, 0);
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_start", hlsm_start, 0);
        @(posedge Clk); #1;
        push(7, 3, 2, 23, 4, 1'b0, w);
        wait_valid(lat);
        chk("post_rst_latency", lat, 9);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hlsm_operand_sequencer.md
Name: hlsm_operand_sequencer

Overview:
- Upstream/downstream companion to the HLSM datapath. Accepts operand triples (a, b, c) on a valid/ready stream and buffers them in a small FIFO.
- Launches one HLSM computation per triple via a single-cycle Start pulse, holding a/b/c stable for the whole run.
- Captures z and x on Done and presents them on a valid/ready result stream.
- Adds a Done timeout so a hung datapath cannot stall the pipeline.

Parameters:
- W, 32, operand/result width; all data is signed two's complement.
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- TIMEOUT, 16, maximum cycles from Start to Done before an error result is emitted; minimum 8.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  FIFO not full.
- in_a / in_b / in_c  in  W each  signed operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_z / out_x  out  W each  signed results.
- out_err  out  1  result produced by timeout; z and x are forced to 0.
- hlsm_start  out  1  drives HLSM Start.
- hlsm_a / hlsm_b / hlsm_c  out  W each  drive HLSM a, b, c.
- hlsm_done  in  1  from HLSM Done.
- hlsm_z / hlsm_x  in  W each  from HLSM z, x.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset clears:
  - FIFO pointers and count.
  - out_valid, out_err, out_z, out_x, hlsm_start, hlsm_a/b/c, and the timeout counter, all to 0.
  - FSM state, to IDLE.
  - Reset asserted mid-operation abandons any in-flight run; a late hlsm_done after reset is ignored because the FSM is in IDLE.
- FIFO:
  - Write when in_valid && in_ready.
  - in_ready = (count != DEPTH).
  - Read pointer advances only on an IDLE->LAUNCH pop.
  - Simultaneous push and pop leaves count unchanged; pushing when full is impossible because in_ready is low.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count != 0, pop the head into hlsm_a/b/c registers and go to LAUNCH.
  - LAUNCH: hlsm_start = 1 for exactly this one cycle; clear the timeout counter; go to BUSY.
  - BUSY:
    - hlsm_start = 0; counter increments each cycle.
    - If hlsm_done: capture hlsm_z/hlsm_x into out_z/out_x, set out_err = 0, and go to HOLD.
    - Else, if counter reaches TIMEOUT-1: out_z = out_x = 0, out_err = 1, and go to HOLD.
    - hlsm_done wins if it coincides with the timeout.
  - HOLD: out_valid = 1; out_z/out_x/out_err stable; on out_ready go to IDLE (out_valid low the next cycle).
- hlsm_a/b/c change only on an IDLE pop and are otherwise held, since the HLSM reads them across several states.
- hlsm_done seen outside BUSY is ignored.
- Latency, with Start high in cycle N:
  - HLSM steps T1..FINAL in cycles N+1..N+5.
  - Done is high in N+6; results are captured at the end of N+6.
  - out_valid rises in N+7.
  - From in_valid accepted into an empty FIFO with FSM in IDLE: IDLE pop at N-1 (the cycle after the write), so the first output appears 9 cycles after acceptance.
- Back-to-back: minimum 9 cycles per triple when out_ready is held high: IDLE, LAUNCH, 6 BUSY, HOLD.
- Results are delivered in strict FIFO order; there is one run in flight at most.

Test Plan:
- Single triple a=5, b=7, c=3, out_ready=1 -> hlsm_start pulses exactly 1 cycle; out_valid 9 cycles after acceptance with z=27, x=3, err=0.
- Signed triple a=-3, b=-1, c=2 -> z=-10, x=-2; also a=10, b=2, c=4 (g=0 path) -> z=54, x=28.
- Burst of 5 triples at full rate with DEPTH=4 -> in_ready drops after 4 accepts, the 5th is accepted after the first pop, and all 5 results emerge in order with correct values.
- Hold out_ready=0 for 20 cycles on a result -> out_valid, z, x, err stable throughout; no new hlsm_start until the handshake; hlsm_a/b/c unchanged during BUSY.
- HLSM model that never asserts Done -> after TIMEOUT cycles the result is z=0, x=0, err=1; the next triple then runs normally with err=0.
- Assert Rst during BUSY, then a late hlsm_done pulse -> no out_valid, FIFO empty, in_ready=1, busy=0; a subsequent triple completes correctly.
